btb_update_ctrl: RTL and testbench

Controller that owns the branch target buffer's single write port. It accepts resolved-branch updates from the execute stage, buffers them in a small in-order queue, and presents them to the BTB one at a time under a ready handshake. It also runs a full-table invalidate sweep on flush requests. It sits between the execute stage and the BTB, and it is the only block allowed to write BTB entries.

---
 rtl/btb_update_ctrl.sv | 110 +++++++++++
 tb/tb_btb_update_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// Sole writer of the BTB: queues resolved-branch updates from execute and
// presents them one at a time, or sweeps every entry invalid on a flush.
module btb_update_ctrl #(
    parameter int BTB_ENTRIES  = 128,
    parameter int INDEX_WIDTH  = $clog2(BTB_ENTRIES),
    parameter int TARGET_WIDTH = 32,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    exValid,
    input  logic [31:0]             exPc,
    input  logic                    exTaken,
    input  logic [TARGET_WIDTH-1:0] exTarget,
    output logic                    exReady,
    input  logic                    flushReq,
    output logic                    flushBusy,
    output logic                    btbWe,
    input  logic                    btbReady,
    output logic                    btbInvalidate,
    output logic [INDEX_WIDTH-1:0]  btbIndex,
    output logic [31:0]             btbPc,
    output logic                    btbTaken,
    output logic [TARGET_WIDTH-1:0] btbTarget,
    output logic [15:0]             dropCount
);

    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam logic [QW:0] DEPTH = (QW+1)'(QUEUE_DEPTH);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(BTB_ENTRIES - 1);

    typedef enum logic {IDLE, SWEEP} stateT;

    stateT                   state;
    logic [INDEX_WIDTH-1:0]  sweepCount;
    logic [QW:0]             wrPtr;
    logic [QW:0]             rdPtr;
    logic [QW:0]             count;
    logic [31:0]             pcMem     [QUEUE_DEPTH];
    logic                    takenMem  [QUEUE_DEPTH];
    logic [TARGET_WIDTH-1:0] targetMem [QUEUE_DEPTH];
    logic                    queueEmpty;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [31:0]             headPc;

    // Pointers carry an extra wrap bit so full and empty differ.
    assign count      = wrPtr - rdPtr;
    assign queueEmpty = (count == '0);
    assign exReady    = (count < DEPTH) && (state == IDLE) && !flushReq;
    assign push       = exValid && exReady;
    assign drop       = exValid && !exReady;
    assign pop        = (state == IDLE) && !queueEmpty && btbReady;
    assign headPc     = pcMem[rdPtr[QW-1:0]];

    assign flushBusy     = (state == SWEEP);
    assign btbWe         = (state == SWEEP) || !queueEmpty;
    assign btbInvalidate = (state == SWEEP);
    assign btbIndex      = (state == SWEEP) ? sweepCount : headPc[INDEX_WIDTH+1:2];
    assign btbPc         = (state == SWEEP) ? '0 : headPc;
    assign btbTaken      = (state == SWEEP) ? 1'b0 : takenMem[rdPtr[QW-1:0]];
    assign btbTarget     = (state == SWEEP) ? '0 : targetMem[rdPtr[QW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr[QW-1:0]]     <= exPc;
            takenMem[wrPtr[QW-1:0]]  <= exTaken;
            targetMem[wrPtr[QW-1:0]] <= exTarget;
        end
    end

    // A flush overrides everything: queue cleared and sweep restarted at 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sweepCount <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
        end else if (flushReq) begin
            state      <= SWEEP;
            sweepCount <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) wrPtr <= wrPtr + 1'b1;
                    if (pop)  rdPtr <= rdPtr + 1'b1;
                end
                SWEEP: begin
                    if (btbReady) begin
                        sweepCount <= sweepCount + 1'b1;
                        if (sweepCount == LAST_INDEX) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dropCount <= '0;
        end else if (drop && (dropCount != 16'hFFFF)) begin
            dropCount <= dropCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: queueing, backpressure, drops,
// invalidate sweeps, flush restart, reset and drop-counter saturation.
module tb_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exValid;
    logic [31:0] exPc;
    logic        exTaken;
    logic [31:0] exTarget;
    logic        exReady;
    logic        flushReq;
    logic        flushBusy;
    logic        btbWe;
    logic        btbReady;
    logic        btbInvalidate;
    logic [6:0]  btbIndex;
    logic [31:0] btbPc;
    logic        btbTaken;
    logic [31:0] btbTarget;
    logic [15:0] dropCount;

    int passed = 0;
    int total  = 0;

    btb_update_ctrl dut (
        .clk(clk), .rst(rst),
        .exValid(exValid), .exPc(exPc), .exTaken(exTaken), .exTarget(exTarget),
        .exReady(exReady), .flushReq(flushReq), .flushBusy(flushBusy),
        .btbWe(btbWe), .btbReady(btbReady), .btbInvalidate(btbInvalidate),
        .btbIndex(btbIndex), .btbPc(btbPc), .btbTaken(btbTaken),
        .btbTarget(btbTarget), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        exValid  = v;
        exPc     = pc;
        exTaken  = tk;
        exTarget = tg;
    endtask

    initial begin
        rst = 1'b0; flushReq = 1'b0; btbReady = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        step(); step();
        checkOutput("resetWe",   64'(btbWe), 64'd0);
        checkOutput("resetBusy", 64'(flushBusy), 64'd0);
        checkOutput("resetDrop", 64'(dropCount), 64'd0);
        checkOutput("resetRdy",  64'(exReady), 64'd1);
        rst = 1'b1;

        // Three updates drained back to back
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h2000);
        step();
        checkOutput("t1Idx0", 64'({btbWe, btbInvalidate, btbIndex}), 64'({2'b10, 7'h40}));
        checkOutput("t1Pay0", 64'({btbPc, btbTaken}), 64'({32'h100, 1'b1}));
        checkOutput("t1Tgt0", 64'(btbTarget), 64'h2000);
        applyStimulus(1'b1, 32'h104, 1'b0, 32'h3000);
        step();
        checkOutput("t1Idx1", 64'({btbWe, btbIndex}), 64'({1'b1, 7'h41}));
        checkOutput("t1Pay1", 64'({btbPc, btbTaken, btbTarget}), 64'({32'h104, 1'b0, 32'h3000}));
        applyStimulus(1'b1, 32'h108, 1'b1, 32'h4000);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("t1Idx2", 64'({btbWe, btbIndex}), 64'({1'b1, 7'h42}));
        checkOutput("t1Pay2", 64'({btbPc, btbTarget}), 64'({32'h108, 32'h4000}));
        step();
        checkOutput("t1Empty", 64'(btbWe), 64'd0);

        // Stalled BTB: four accepted, fifth dropped
        btbReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(4 * i), 1'b0, 32'h5000 + 32'(i));
            step();
        end
        applyStimulus(1'b1, 32'h210, 1'b0, 32'h5004);
        checkOutput("t2FullRdy", 64'(exReady), 64'd0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("t2Drop", 64'(dropCount), 64'd1);
        checkOutput("t2Held", 64'({btbWe, btbPc}), 64'({1'b1, 32'h200}));
        step();
        checkOutput("t2Held2", 64'({btbWe, btbPc, btbTarget}), 64'({1'b1, 32'h200, 32'h5000}));
        btbReady = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            checkOutput("t2Drain", 64'({btbWe, btbPc, btbTarget}), 64'({1'b1, 32'h200 + 32'(4 * i), 32'h5000 + 32'(i)}));
        end
        step();
        checkOutput("t2Done", 64'({btbWe, exReady}), 64'({1'b0, 1'b1}));

        // Flush with two queued entries
        btbReady = 1'b0;
        applyStimulus(1'b1, 32'h300, 1'b1, 32'h6000);
        step();
        applyStimulus(1'b1, 32'h304, 1'b1, 32'h6004);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        flushReq = 1'b1; btbReady = 1'b1;
        #1;
        checkOutput("t3FlushRdy", 64'(exReady), 64'd0);
        step();
        flushReq = 1'b0;
        for (int i = 0; i < 128; i++) begin
            checkOutput("t3Sweep", 64'({btbWe, btbInvalidate, flushBusy, btbIndex, btbPc, btbTaken}),
                        64'({3'b111, 7'(i), 32'h0, 1'b0}));
            step();
        end
        checkOutput("t3End", 64'({flushBusy, btbWe, exReady}), 64'({1'b0, 1'b0, 1'b1}));

        // Sweep with btbReady alternating: 256 cycles, each index once
        flushReq = 1'b1;
        step();
        flushReq = 1'b0;
        for (int c = 0; c < 256; c++) begin
            btbReady = c[0];
            checkOutput("t4Toggle", 64'({flushBusy, btbIndex}), 64'({1'b1, 7'(c / 2)}));
            step();
        end
        checkOutput("t4End", 64'({flushBusy, exReady}), 64'({1'b0, 1'b1}));

        // Second flush at index 50 restarts at 0
        btbReady = 1'b1;
        flushReq = 1'b1;
        step();
        flushReq = 1'b0;
        repeat (50) step();
        checkOutput("t4At50", 64'({flushBusy, btbIndex}), 64'({1'b1, 7'd50}));
        flushReq = 1'b1;
        step();
        flushReq = 1'b0;
        checkOutput("t4Restart", 64'({flushBusy, btbIndex}), 64'({1'b1, 7'd0}));

        // Reset mid-sweep at index 60
        repeat (60) step();
        checkOutput("t5At60", 64'(btbIndex), 64'd60);
        rst = 1'b0;
        step();
        rst = 1'b1;
        checkOutput("t5Reset", 64'({btbWe, flushBusy, exReady}), 64'({1'b0, 1'b0, 1'b1}));
        checkOutput("t5Drop", 64'(dropCount), 64'd0);

        // Drop counter saturation under a long stall
        btbReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(4 * i), 1'b1, 32'h7000);
            step();
        end
        repeat (10) step();
        checkOutput("t6Drop10", 64'(dropCount), 64'd10);
        repeat (69990) step();
        checkOutput("t6Sat", 64'(dropCount), 64'hFFFF);
        checkOutput("t6Held", 64'({btbWe, btbPc}), 64'({1'b1, 32'h400}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
